mc_rca: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, holding the carry in a register between chunks. A start/busy/done handshake controls it, and it supports add and subtract modes. It is the sequential successor to the 4-bit combinational adder: the datapath stays narrow, and wider operands cost extra cycles.

---
 rtl/mc_rca.sv | 132 +++++++++++++
 tb/tb_mc_rca.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_rca.sv
// ============================================================================
// Module   : mc_rca
// Purpose  : Multi-cycle ripple-carry adder/subtractor, CHUNK bits per clock.
//            Define MC_RCA_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_rca #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef MC_RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] c_last = IDX_W'(N - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("mc_rca: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;

    logic [CHUNK-1:0] w_sum;
    logic             w_cout;
`ifdef MC_RCA_OVF_EN
    logic             w_msb_cin;
`endif

    // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
    always_comb begin
        w_sum  = '0;
        w_cout = r_carry;
`ifdef MC_RCA_OVF_EN
        w_msb_cin = 1'b0;
`endif
        for (int i = 0; i < CHUNK; i++) begin
`ifdef MC_RCA_OVF_EN
            if (i == CHUNK - 1) begin
                w_msb_cin = w_cout;
            end
`endif
            w_sum[i] = r_a[i] ^ r_b[i] ^ w_cout;
            w_cout   = (r_a[i] & r_b[i]) | (w_cout & (r_a[i] ^ r_b[i]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
`ifdef MC_RCA_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= op_sub ? ~b : b;
                        r_carry <= ci ^ op_sub;
                        r_idx   <= '0;
                        s       <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    s[int'(r_idx) * CHUNK +: CHUNK] <= w_sum;
                    r_carry <= w_cout;
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    if (r_idx == c_last) begin
                        co      <= w_cout;
`ifdef MC_RCA_OVF_EN
                        ovf     <= w_cout ^ w_msb_cin;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_rca.sv
// ============================================================================
// Module   : tb_mc_rca
// Purpose  : Directed self-checking bench for mc_rca (8/2 and 4/4 instances).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_rca;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8;
    logic [7:0] s8;

    logic       start4 = 1'b0, sub4 = 1'b0, ci4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, co4;
    logic [3:0] s4;

`ifdef MC_RCA_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_rca #(.WIDTH(8), .CHUNK(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .op_sub(sub8),
        .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
`ifdef MC_RCA_OVF_EN
        , .ovf(ovf8)
`endif
    );

    mc_rca #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .op_sub(sub4),
        .a(a4), .b(b4), .ci(ci4),
        .busy(busy4), .done(done4), .s(s4), .co(co4)
`ifdef MC_RCA_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Presents one start for a single rising edge; call just after a falling edge.
    task automatic drive_start(input bit sel, input logic [7:0] ta, input logic [7:0] tb,
                               input logic tci, input logic tsub);
        if (sel) begin
            a4 = ta[3:0]; b4 = tb[3:0]; ci4 = tci; sub4 = tsub; start4 = 1'b1;
        end else begin
            a8 = ta; b8 = tb; ci8 = tci; sub8 = tsub; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; start4 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; a4 = 4'hA; b4 = 4'h5;
    endtask

    // edges counts the sampling edge as 1; -1 means done never appeared.
    task automatic wait_done(input bit sel, output int edges, output int busy_n, output int both);
        logic bsy, dn;
        edges = -1; busy_n = 0; both = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bsy = sel ? busy4 : busy8;
            dn  = sel ? done4 : done8;
            if (bsy && dn) both++;
            if (dn) begin
                edges = k + 1;
                break;
            end
            if (bsy) busy_n++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({busy8, done8, s8, co8} !== 11'h0) begin
            errors++; $display("FAIL reset_async got %h exp 000", {busy8, done8, s8, co8});
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({busy8, done8, s8, co8, busy4, done4, s4, co4} !== 18'h0) begin
            errors++; $display("FAIL reset_held got %h exp 00000", {busy8, done8, s8, co8, busy4, done4, s4, co4});
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf8); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset got %b exp 00", {busy8, done8});
        end
    endtask

    task automatic test_add;
        int e, bn, bo;
        drive_start(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if (e !== 5) begin errors++; $display("FAIL add_latency got %0d exp 5", e); end
        checks++;
        if (bn !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d exp 4", bn); end
        checks++;
        if (bo !== 0) begin errors++; $display("FAIL add_busy_done_overlap got %0d exp 0", bo); end
        checks++;
        if ({s8, co8} !== {8'h10, 1'b0}) begin
            errors++; $display("FAIL add_0f_01 got s=%h co=%b exp s=10 co=0", s8, co8);
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin errors++; $display("FAIL add_0f_01_ovf got %b exp 0", ovf8); end
`endif
        @(negedge clk);
        checks++;
        if ({done8, s8, co8} !== {1'b0, 8'h10, 1'b0}) begin
            errors++; $display("FAIL add_hold got done=%b s=%h exp done=0 s=10", done8, s8);
        end

        drive_start(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'hFF, 1'b1} || e !== 5) begin
            errors++; $display("FAIL add_ff_ff_ci got s=%h co=%b edges=%0d exp s=ff co=1 edges=5", s8, co8, e);
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin errors++; $display("FAIL add_ff_ff_ovf got %b exp 0", ovf8); end
`endif
        drive_start(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h80, 1'b0}) begin
            errors++; $display("FAIL add_7f_01 got s=%h co=%b exp s=80 co=0", s8, co8);
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b1) begin errors++; $display("FAIL add_7f_01_ovf got %b exp 1", ovf8); end
`endif
    endtask

    task automatic test_sub;
        int e, bn, bo;
        drive_start(1'b0, 8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'hFE, 1'b0} || e !== 5) begin
            errors++; $display("FAIL sub_05_07 got s=%h co=%b edges=%0d exp s=fe co=0 edges=5", s8, co8, e);
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b0) begin errors++; $display("FAIL sub_05_07_ovf got %b exp 0", ovf8); end
`endif
        drive_start(1'b0, 8'h80, 8'h01, 1'b0, 1'b1);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h7F, 1'b1}) begin
            errors++; $display("FAIL sub_80_01 got s=%h co=%b exp s=7f co=1", s8, co8);
        end
`ifdef MC_RCA_OVF_EN
        checks++;
        if (ovf8 !== 1'b1) begin errors++; $display("FAIL sub_80_01_ovf got %b exp 1", ovf8); end
`endif
        // Borrow-in: 0x10 - 0x01 - 1 = 0x0E, no borrow out.
        drive_start(1'b0, 8'h10, 8'h01, 1'b1, 1'b1);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h0E, 1'b1}) begin
            errors++; $display("FAIL sub_borrow_in got s=%h co=%b exp s=0e co=1", s8, co8);
        end
    endtask

    task automatic test_back_to_back;
        int e, bn, bo;
        drive_start(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if (s8 !== 8'h46) begin errors++; $display("FAIL b2b_first got s=%h exp 46", s8); end
        // Still inside the DONE cycle: issue the next start immediately.
        drive_start(1'b0, 8'hC8, 8'h64, 1'b0, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h2C, 1'b1} || e !== 5 || bn !== 4) begin
            errors++; $display("FAIL b2b_second got s=%h co=%b edges=%0d busy=%0d exp s=2c co=1 edges=5 busy=4",
                               s8, co8, e, bn);
        end

        drive_start(1'b0, 8'h21, 8'h11, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        drive_start(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h32, 1'b0} || e !== 3) begin
            errors++; $display("FAIL ignored_start got s=%h co=%b edges=%0d exp s=32 co=0 edges=3", s8, co8, e);
        end
        wait_done(1'b0, e, bn, bo);
        checks++;
        if (e !== -1 || bn !== 0) begin
            errors++; $display("FAIL ignored_start_no_queue got edges=%0d busy=%0d exp edges=-1 busy=0", e, bn);
        end
    endtask

    task automatic test_reset_mid_run;
        int e, bn, bo;
        drive_start(1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        checks++;
        if ({busy8, s8[3:0]} !== {1'b1, 4'h5}) begin
            errors++; $display("FAIL mid_run_partial got busy=%b s=%h exp busy=1 s[3:0]=5", busy8, s8);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, s8, co8} !== 11'h0) begin
            errors++; $display("FAIL mid_run_reset got %h exp 000", {busy8, done8, s8, co8});
        end
        @(negedge clk);
        reset_n = 1'b1;
        wait_done(1'b0, e, bn, bo);
        checks++;
        if (e !== -1 || bn !== 0) begin
            errors++; $display("FAIL mid_run_no_done got edges=%0d busy=%0d exp edges=-1 busy=0", e, bn);
        end
        drive_start(1'b0, 8'h3C, 8'h0A, 1'b0, 1'b0);
        wait_done(1'b0, e, bn, bo);
        checks++;
        if ({s8, co8} !== {8'h46, 1'b0} || e !== 5) begin
            errors++; $display("FAIL after_reset_op got s=%h co=%b edges=%0d exp s=46 co=0 edges=5", s8, co8, e);
        end
    endtask

    task automatic test_degenerate;
        int e, bn, bo;
        drive_start(1'b1, 8'h07, 8'h07, 1'b0, 1'b0);
        wait_done(1'b1, e, bn, bo);
        checks++;
        if ({s4, co4} !== {4'hE, 1'b0}) begin
            errors++; $display("FAIL w4_add got s=%h co=%b exp s=e co=0", s4, co4);
        end
        checks++;
        if (e !== 2 || bn !== 1) begin
            errors++; $display("FAIL w4_latency got edges=%0d busy=%0d exp edges=2 busy=1", e, bn);
        end
        drive_start(1'b1, 8'h03, 8'h05, 1'b0, 1'b1);
        wait_done(1'b1, e, bn, bo);
        checks++;
        if ({s4, co4} !== {4'hE, 1'b0}) begin
            errors++; $display("FAIL w4_sub got s=%h co=%b exp s=e co=0", s4, co4);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
